// File: rtl/lsu_mem_ctrl.sv
// Load/store unit driving a single-cycle word memory: one RV32I load or store at a time,
// with sub-word extraction/extension on loads and read-modify-write for byte/halfword stores.
module lsu_mem_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_wEn,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data
);

    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

    state_t            state_reg, state_next;
    logic [2:0]        funct3_reg, funct3_next;
    logic [1:0]        offset_reg, offset_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic              err_reg, err_next;
    logic [ADDR_W-1:0] address_reg, address_next;
    logic [DATA_W-1:0] write_data_reg, write_data_next;
    logic [DATA_W-1:0] resp_rdata_reg, resp_rdata_next;

    // Byte-address bits above the word-address field are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

    // Request classification, evaluated on the live request inputs at accept time.
    logic req_illegal, req_misaligned;
    always_comb begin
        if (req_we)
            req_illegal = !(req_funct3 == 3'b000 || req_funct3 == 3'b001 || req_funct3 == 3'b010);
        else
            req_illegal = (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111);
        req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                         ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    end

    // Load extraction and extension from the currently addressed word.
    logic [7:0]        load_byte;
    logic [15:0]       load_half;
    logic [DATA_W-1:0] load_ext;
    always_comb begin
        load_byte = read_data[8*offset_reg +: 8];
        load_half = offset_reg[1] ? read_data[31:16] : read_data[15:0];
        case (funct3_reg)
            3'b000:  load_ext = {{24{load_byte[7]}}, load_byte};
            3'b100:  load_ext = {24'h000000, load_byte};
            3'b001:  load_ext = {{16{load_half[15]}}, load_half};
            3'b101:  load_ext = {16'h0000, load_half};
            default: load_ext = read_data;
        endcase
    end

    // Sub-word store merge: each byte lane takes new data only if the access covers it.
    logic [DATA_W-1:0] merged_word;
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic lane_hit;
            assign lane_hit = (funct3_reg == 3'b000) ? (offset_reg == 2'(gi))
                                                     : (offset_reg[1] == 1'(gi >> 1));
            assign merged_word[8*gi +: 8] = !lane_hit ? read_data[8*gi +: 8] :
                                            (funct3_reg == 3'b000) ? wdata_reg[7:0]
                                                                   : wdata_reg[8*(gi % 2) +: 8];
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        funct3_next     = funct3_reg;
        offset_next     = offset_reg;
        wdata_next      = wdata_reg;
        err_next        = err_reg;
        address_next    = address_reg;
        write_data_next = write_data_reg;
        resp_rdata_next = resp_rdata_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    funct3_next  = req_funct3;
                    offset_next  = req_addr[1:0];
                    wdata_next   = req_wdata;
                    address_next = req_addr[ADDR_W+1:2];
                    if (req_illegal || req_misaligned) begin
                        err_next        = 1'b1;
                        resp_rdata_next = '0;
                        state_next      = RESP;
                    end else begin
                        err_next = 1'b0;
                        if (!req_we) begin
                            state_next = LOAD;
                        end else if (req_funct3 == 3'b010) begin
                            write_data_next = req_wdata;
                            state_next      = WRITE;
                        end else begin
                            state_next = RMW_RD;
                        end
                    end
                end
            end
            LOAD: begin
                resp_rdata_next = load_ext;
                state_next      = RESP;
            end
            RMW_RD: begin
                write_data_next = merged_word;
                state_next      = WRITE;
            end
            WRITE: begin
                resp_rdata_next = '0;
                state_next      = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            funct3_reg     <= '0;
            offset_reg     <= '0;
            wdata_reg      <= '0;
            err_reg        <= 1'b0;
            address_reg    <= '0;
            write_data_reg <= '0;
            resp_rdata_reg <= '0;
        end else begin
            funct3_reg     <= funct3_next;
            offset_reg     <= offset_next;
            wdata_reg      <= wdata_next;
            err_reg        <= err_next;
            address_reg    <= address_next;
            write_data_reg <= write_data_next;
            resp_rdata_reg <= resp_rdata_next;
        end
    end

    // Gating with rst keeps a reset cycle from writing memory or signalling completion.
    assign req_ready  = (state_reg == IDLE);
    assign mem_wEn    = (state_reg == WRITE) & ~rst;
    assign resp_valid = (state_reg == RESP) & ~rst;
    assign resp_err   = err_reg;
    assign resp_rdata = resp_rdata_reg;
    assign address    = address_reg;
    assign write_data = write_data_reg;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl against a combinational-read word memory.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_wEn;
    logic [15:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;

    logic [31:0] mem [0:65535];

    int tests  = 0;
    int errors = 0;

    // Results of the most recent transaction
    int          lat;
    int          wen_cnt;
    logic [31:0] wen_addr;
    logic [31:0] wen_data;
    logic [31:0] got_rdata;
    logic        got_err;
    logic        got_valid;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.ADDR_W(16), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_wEn    (mem_wEn),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data)
    );

    assign read_data = mem[address];
    always @(posedge clk) if (mem_wEn) mem[address] <= write_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request and observe until resp_valid (bounded to 8 cycles).
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd);
        @(negedge clk);
        chk("req_ready_before", {31'b0, req_ready}, 32'h1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b111; req_addr = 32'hFFFF_FFFF;
        req_wdata = 32'hDEAD_BEEF;
        lat = 0; wen_cnt = 0; got_valid = 1'b0; wen_addr = '0; wen_data = '0;
        while (!got_valid && lat < 8) begin
            @(negedge clk);
            lat++;
            if (mem_wEn) begin
                wen_cnt++;
                wen_addr = {16'h0, address};
                wen_data = write_data;
            end
            if (resp_valid) begin
                got_valid = 1'b1;
                got_rdata = resp_rdata;
                got_err   = resp_err;
            end
        end
        chk("resp_seen", {31'b0, got_valid}, 32'h1);
        $display("[TB] we=%0b f3=%03b addr=0x%08h wd=0x%08h -> lat=%0d err=%0b rdata=0x%08h wEn=%0d",
                 we, f3, addr, wd, lat, got_err, got_rdata, wen_cnt);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;

        // 1. Reset
        repeat (2) begin
            @(negedge clk);
            chk("rst_wen", {31'b0, mem_wEn}, 32'h0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_valid", {31'b0, resp_valid}, 32'h0);
        chk("rst_err", {31'b0, resp_err}, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_wen2", {31'b0, mem_wEn}, 32'h0);
        chk("rst_addr", {16'h0, address}, 32'h0);
        chk("rst_wdata", write_data, 32'h0);

        // 2. SW then LW
        do_req(1'b1, 3'b010, 32'h0000_01BC, 32'h1110_0011);
        chk("sw_lat", lat, 2);
        chk("sw_err", {31'b0, got_err}, 32'h0);
        chk("sw_rdata", got_rdata, 32'h0);
        chk("sw_wen_cnt", wen_cnt, 1);
        chk("sw_wen_addr", wen_addr, 32'h0000_006F);
        chk("sw_wen_data", wen_data, 32'h1110_0011);
        @(negedge clk);
        chk("resp_one_cycle", {31'b0, resp_valid}, 32'h0);
        chk("addr_hold", {16'h0, address}, 32'h0000_006F);
        chk("sw_mem", mem[16'h006F], 32'h1110_0011);
        do_req(1'b0, 3'b010, 32'h0000_01BC, 32'h0);
        chk("lw_lat", lat, 2);
        chk("lw_rdata", got_rdata, 32'h1110_0011);
        chk("lw_wen", wen_cnt, 0);

        // 3. SB, LB, LBU
        do_req(1'b1, 3'b000, 32'h0000_01BD, 32'h0000_00AA);
        chk("sb_lat", lat, 3);
        chk("sb_wen_cnt", wen_cnt, 1);
        chk("sb_wen_data", wen_data, 32'h1110_AA11);
        chk("sb_mem", mem[16'h006F], 32'h1110_AA11);
        do_req(1'b0, 3'b000, 32'h0000_01BD, 32'h0);
        chk("lb_rdata", got_rdata, 32'hFFFF_FFAA);
        do_req(1'b0, 3'b100, 32'h0000_01BD, 32'h0);
        chk("lbu_rdata", got_rdata, 32'h0000_00AA);

        // 4. SH, LH, LHU
        do_req(1'b1, 3'b001, 32'h0000_01BE, 32'h0000_8001);
        chk("sh_lat", lat, 3);
        chk("sh_err", {31'b0, got_err}, 32'h0);
        chk("sh_mem", mem[16'h006F], 32'h8001_AA11);
        do_req(1'b0, 3'b001, 32'h0000_01BE, 32'h0);
        chk("lh_rdata", got_rdata, 32'hFFFF_8001);
        do_req(1'b0, 3'b101, 32'h0000_01BE, 32'h0);
        chk("lhu_rdata", got_rdata, 32'h0000_8001);
        do_req(1'b0, 3'b101, 32'h0000_01BC, 32'h0);
        chk("lhu_lo_rdata", got_rdata, 32'h0000_AA11);

        // 5. Errors
        do_req(1'b0, 3'b010, 32'h0000_01BD, 32'h0);
        chk("lw_mis_lat", lat, 1);
        chk("lw_mis_err", {31'b0, got_err}, 32'h1);
        chk("lw_mis_rdata", got_rdata, 32'h0);
        chk("lw_mis_wen", wen_cnt, 0);
        do_req(1'b0, 3'b011, 32'h0000_01BC, 32'h0);
        chk("ld_ill_lat", lat, 1);
        chk("ld_ill_err", {31'b0, got_err}, 32'h1);
        chk("ld_ill_rdata", got_rdata, 32'h0);
        do_req(1'b1, 3'b001, 32'h0000_01BD, 32'h0000_1234);
        chk("sh_mis_err", {31'b0, got_err}, 32'h1);
        chk("sh_mis_wen", wen_cnt, 0);
        do_req(1'b1, 3'b100, 32'h0000_01BC, 32'h0000_5678);
        chk("st_ill_err", {31'b0, got_err}, 32'h1);
        chk("st_ill_wen", wen_cnt, 0);
        chk("err_mem", mem[16'h006F], 32'h8001_AA11);

        // 6. Reset during RMW_RD
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h0000_01BC; req_wdata = 32'h0000_0055;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("abort_in_rmw_ready", {31'b0, req_ready}, 32'h0);
        rst = 1'b1;
        wen_cnt = 0; got_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (mem_wEn) wen_cnt++;
            if (resp_valid) got_valid = 1'b1;
        end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (mem_wEn) wen_cnt++;
            if (resp_valid) got_valid = 1'b1;
        end
        $display("[TB] reset during RMW_RD -> wEn=%0d resp=%0b", wen_cnt, got_valid);
        chk("abort_wen", wen_cnt, 0);
        chk("abort_resp", {31'b0, got_valid}, 32'h0);
        chk("abort_mem", mem[16'h006F], 32'h8001_AA11);
        chk("abort_ready", {31'b0, req_ready}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store unit: the CPU-side initiator that drives the data memory's word interface (mem_wEn, address, write_data, read_data).
- Accepts one RV32I load/store request at a time from the execute stage.
- Handles byte/halfword extraction with sign/zero extension on loads, and read-modify-write for sub-word stores.
- Flags misaligned or illegal accesses without touching memory.

Parameters:
- ADDR_W, 16, word-address width driven to data memory.
- DATA_W, 32, data word width (fixed 32; other values unsupported).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; accept = req_valid & req_ready at posedge.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 of the load/store.
- req_addr  in  32  byte address; bits [ADDR_W+1:2] form the word address; higher bits ignored.
- req_wdata  in  32  store data (rs2).
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors; holds until next response.
- resp_err  out  1  misaligned/illegal access; meaningful only with resp_valid.
- mem_wEn  out  1  data memory write enable.
- address  out  ADDR_W  data memory word address.
- write_data  out  32  data memory write word.
- read_data  in  32  data memory read word; combinational from address, no latency.

Behaviour:
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- Reset (sync, at posedge with rst=1): state to IDLE; address, write_data, resp_rdata to 0; resp_valid, resp_err to 0.
- mem_wEn = (state==WRITE) & ~rst, so a reset cycle never writes memory.
- Reset mid-operation aborts the request with no response and no write.
- IDLE, on accept: latch funct3, byte offset addr[1:0], and wdata; address <= req_addr[ADDR_W+1:2].
  - Illegal funct3 goes to RESP with err. Loads: 011, 110, 111 are illegal. Stores: any funct3 other than 000/001/010 is illegal.
  - Misaligned goes to RESP with err: half with addr[0]=1, word with addr[1:0]!=0.
  - Legal load goes to LOAD.
  - SW goes to WRITE with write_data=req_wdata.
  - SB/SH go to RMW_RD.
- LOAD: sample read_data; select byte/half by offset; extend.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Capture into resp_rdata, then go to RESP.
- RMW_RD: merge into read_data and write the result to write_data, then go to WRITE.
  - SB: req_wdata[7:0] into byte lane offset.
  - SH: req_wdata[15:0] into half lane offset[1].
- WRITE: mem_wEn=1 for exactly one cycle; memory writes at the closing posedge; go to RESP. address/write_data stay stable through WRITE.
- RESP: resp_valid=1 for one cycle; resp_err set per the cause; then go to IDLE.
  - resp_rdata=0 for stores and errors.
- Latency, counting cycle 1 as the cycle after the accept edge:
  - Error: resp_valid in cycle 1.
  - Load and SW: resp_valid in cycle 2.
  - SB/SH: resp_valid in cycle 3.
  - Next accept is possible in the cycle after RESP.
- req_valid is ignored outside IDLE. Request inputs need only be valid at the accept edge.
- address holds its last value after completion; mem_wEn is never high outside WRITE.

Test Plan:
1. Reset: rst=1 for 2 cycles, then 0 -> all outputs 0, req_ready=1, mem_wEn never high.
2. SW addr 0x000001BC, data 0x11100011 -> mem_wEn high exactly 1 cycle with address=0x006f, write_data=0x11100011; resp_valid in cycle 2, resp_err=0. Then LW 0x1BC -> resp_rdata=0x11100011.
3. SB addr 0x1BD, wdata 0x000000AA -> word becomes 0x1110AA11; resp_valid in cycle 3. Then LB 0x1BD -> 0xFFFFFFAA, LBU 0x1BD -> 0x000000AA.
4. SH addr 0x1BE, wdata 0x00008001 -> word becomes 0x8001AA11. Then LH 0x1BE -> 0xFFFF8001, LHU 0x1BE -> 0x00008001.
5. LW 0x1BD (misaligned) and load funct3=011 -> resp_valid in cycle 1, resp_err=1, resp_rdata=0; no mem_wEn; memory word unchanged.
6. SB 0x1BC issued, rst asserted during RMW_RD -> no mem_wEn pulse, no resp_valid, word still 0x8001AA11, FSM in IDLE with req_ready=1 after rst drops.
